pingpong_frame_writer: RTL and testbench
========================================

// Module: pingpong_frame_writer
// PURPOSE
//  Upstream write controller for the two-bank (ping-pong) frame BRAM.
//  Accepts a valid/ready pixel stream, writes each frame into the free bank,
//  and hands each completed bank to the downstream reader (frm_valid/frm_release).
//  Backpressures the source when both banks hold unreleased frames.
// PARAMETERS
//  DATA_WIDTH  8    pixel width; matches BRAM data width
//  ADDR_WIDTH  16   BRAM address width; must satisfy 2*IMG_W*IMG_H <= 2**ADDR_WIDTH
//  IMG_W       28   frame width in pixels
//  IMG_H       28   frame height in pixels (FRAME = IMG_W*IMG_H = 784)
// PORTS
//  clk          in   1           single clock; all logic on posedge
//  rst_n        in   1           asynchronous active-low reset
//  s_valid      in   1           source pixel valid
//  s_data       in   DATA_WIDTH  source pixel
//  s_sof        in   1           start-of-frame marker, qualified by accept
//  s_ready      out  1           controller can accept a pixel
//  wr_en        out  1           BRAM write enable (port B)
//  wr_addr      out  ADDR_WIDTH  BRAM write address
//  wr_data      out  DATA_WIDTH  BRAM write data
//  frm_valid    out  1           a committed frame is ready for the reader
//  frm_bank     out  1           bank index of the offered frame
//  frm_base     out  ADDR_WIDTH  base address of the offered frame (0 or FRAME)
//  frm_release  in   1           one-cycle pulse: reader has finished the offered frame
//  err_sticky   out  1           protocol error seen; cleared only by reset
// BEHAVIOUR
//  - Accept = s_valid & s_ready on a posedge (edge E0). s_ready = ~full_w[wr_bank],
//    from registers only (no combinational path from s_valid).
//  - Write pipe, 1 cycle: after E0, wr_en=1, wr_data=s_data,
//    wr_addr = wr_bank*FRAME + pix_cnt; BRAM commits on the next edge E1.
//    wr_en=0 in any cycle following an edge with no accept.
//  - pix_cnt range 0..FRAME-1. On accept of pix_cnt==FRAME-1: pix_cnt<=0,
//    full_w[wr_bank]<=1, wr_bank toggles (all at E0).
//  - Commit flag full_r[b] is set at E1, coincident with the last write.
//    A reader issuing rd_en after frm_valid therefore sees committed data.
//  - Reader side: frm_valid = full_r[rd_bank]; frm_bank = rd_bank;
//    frm_base = rd_bank ? FRAME : 0.
//  - frm_release while frm_valid=1: clears full_w and full_r of rd_bank,
//    rd_bank toggles. frm_release while frm_valid=0: ignored, err_sticky<=1.
//  - Simultaneous release and last-pixel accept on the same edge: both take effect.
//    Release of the stalled wr_bank makes s_ready=1 the following cycle.
//  - s_sof accepted with pix_cnt!=0: that pixel is written at the current bank
//    base, pix_cnt<=1, err_sticky<=1, and the partial frame is discarded.
//    s_sof with pix_cnt==0 is normal; a missing s_sof at pixel 0 is not an error.
//  - Reset (async, any time, including mid-frame): pix_cnt, wr_bank, rd_bank,
//    and all full flags =0; wr_en=0, wr_addr=0, wr_data=0, frm_valid=0,
//    frm_bank=0, frm_base=0, err_sticky=0; s_ready=1.
//    Any partial or unreleased frame is discarded.
//  - Address arithmetic is ADDR_WIDTH wide and never exceeds 2*FRAME-1; no wrap.
// TESTING (defaults, FRAME=784)
//  1 Stream 784 px, s_data=i[7:0], s_valid held 1 -> wr_addr 0..783 one cycle after
//    each accept, wr_data matches; frm_valid=1 the edge after the 784th accept,
//    frm_bank=0, frm_base=0.
//  2 Stream 1568 px, no release -> second frame at addr 784..1567; s_ready=0 the
//    cycle after the 1568th accept; with s_valid held, no wr_en.
//  3 Then pulse frm_release -> next cycle frm_bank=1, frm_base=784, s_ready=1;
//    next pixel written at addr 0.
//  4 frm_release on the same edge as the final accept of the bank-1 frame ->
//    rd_bank=1; frm_valid=0 for one cycle, then 1 with frm_base=784; s_ready stays 1.
//  5 s_sof with pixel 100 -> that pixel at addr 0, err_sticky=1;
//    frm_valid only after 783 further accepts.
//  6 rst_n low at pixel 300 -> outputs 0 immediately, s_ready=1; next pixel at
//    addr 0. frm_release with frm_valid=0 -> err_sticky=1, no state change.

Source files
------------

// File: rtl/pingpong_frame_writer.sv
// Write side of the two-bank frame buffer: streams pixels into the free bank and
// offers each completed bank to the reader until it is released.
module pingpong_frame_writer #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 16,
   parameter int IMG_W      = 28,
   parameter int IMG_H      = 28
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_valid,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_sof,
   output logic                  s_ready,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  frm_valid,
   output logic                  frm_bank,
   output logic [ADDR_WIDTH-1:0] frm_base,
   input  logic                  frm_release,
   output logic                  err_sticky
);

   localparam int FRAME = IMG_W * IMG_H;
   localparam logic [ADDR_WIDTH-1:0] FRAME_A  = ADDR_WIDTH'(FRAME);
   localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(FRAME - 1);

   logic [ADDR_WIDTH-1:0] pix_cnt;
   logic                  wr_bank;
   logic                  rd_bank;
   logic [1:0]            full_w;
   logic [1:0]            full_r;
   logic                  commit_pend;
   logic                  commit_bank;

   logic                  accept;
   logic                  sof_restart;
   logic                  last_pix;
   logic                  rel_ok;
   logic                  rel_bad;
   logic [ADDR_WIDTH-1:0] pix_idx;
   logic [ADDR_WIDTH-1:0] wr_base;
   logic [1:0]            set_w;
   logic [1:0]            set_r;
   logic [1:0]            clr_mask;

   assign s_ready   = ~full_w[wr_bank];
   assign frm_valid = full_r[rd_bank];
   assign frm_bank  = rd_bank;
   assign frm_base  = rd_bank ? FRAME_A : '0;

   // A mid-frame start-of-frame restarts the bank at its base, dropping the partial frame.
   always_comb begin
      accept      = s_valid & s_ready;
      sof_restart = accept & s_sof & (pix_cnt != '0);
      pix_idx     = sof_restart ? '0 : pix_cnt;
      last_pix    = accept & ~sof_restart & (pix_cnt == LAST_PIX);
      wr_base     = wr_bank ? FRAME_A : '0;
      rel_ok      = frm_release & frm_valid;
      rel_bad     = frm_release & ~frm_valid;
      set_w       = last_pix    ? (2'b01 << wr_bank)     : 2'b00;
      set_r       = commit_pend ? (2'b01 << commit_bank) : 2'b00;
      clr_mask    = rel_ok      ? (2'b01 << rd_bank)     : 2'b00;
   end

   // The reader-visible flag lags the writer flag by one edge so it rises with the last BRAM write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_cnt     <= '0;
         wr_bank     <= 1'b0;
         rd_bank     <= 1'b0;
         full_w      <= 2'b00;
         full_r      <= 2'b00;
         commit_pend <= 1'b0;
         commit_bank <= 1'b0;
         err_sticky  <= 1'b0;
         wr_en       <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
      end else begin
         wr_en       <= accept;
         commit_pend <= last_pix;
         if (last_pix) begin
            commit_bank <= wr_bank;
         end
         if (accept) begin
            wr_addr <= wr_base + pix_idx;
            wr_data <= s_data;
            pix_cnt <= last_pix ? '0 : pix_idx + 1'b1;
         end
         if (last_pix) begin
            wr_bank <= ~wr_bank;
         end
         if (rel_ok) begin
            rd_bank <= ~rd_bank;
         end
         full_w     <= (full_w | set_w) & ~clr_mask;
         full_r     <= (full_r | set_r) & ~clr_mask;
         err_sticky <= err_sticky | sof_restart | rel_bad;
      end
   end

endmodule

// File: tb/tb_pingpong_frame_writer.sv
// Scoreboarded bench for pingpong_frame_writer: directed streams, stalls, releases,
// mid-frame start-of-frame and mid-frame reset.
module tb_pingpong_frame_writer;

   localparam int DW    = 8;
   localparam int AW    = 16;
   localparam int FRAME = 784;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          s_valid = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic          s_sof = 1'b0;
   logic          s_ready;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          frm_valid;
   logic          frm_bank;
   logic [AW-1:0] frm_base;
   logic          frm_release = 1'b0;
   logic          err_sticky;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_exp;
   int  vec_count  = 0;
   int  miss_count = 0;

   always #5 clk = ~clk;

   pingpong_frame_writer #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .IMG_W(28),
      .IMG_H(28)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .s_valid(s_valid),
      .s_data(s_data),
      .s_sof(s_sof),
      .s_ready(s_ready),
      .wr_en(wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .frm_valid(frm_valid),
      .frm_bank(frm_bank),
      .frm_base(frm_base),
      .frm_release(frm_release),
      .err_sticky(err_sticky)
   );

   // Every BRAM write must match the oldest outstanding expected write.
   always @(negedge clk) begin
      if (rst_n && wr_en) begin
         vec_count++;
         if (exp_q.size() == 0) begin
            miss_count++;
            $display("[TB] FAIL unexpected_write: got addr %0d data %0d, required no write",
                     wr_addr, wr_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if (wr_addr !== mon_exp.addr || wr_data !== mon_exp.data) begin
               miss_count++;
               $display("[TB] FAIL write: got addr %0d data %0d, required addr %0d data %0d",
                        wr_addr, wr_data, mon_exp.addr, mon_exp.data);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      vec_count++;
      if (actual !== expected) begin
         miss_count++;
         $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
      end
   endtask

   // Offers one pixel, waits (bounded) for s_ready, and books the write it should produce.
   task automatic applyStimulus(input logic [DW-1:0] data, input logic sof, input int addr);
      bit got = 1'b0;
      s_valid = 1'b1;
      s_data  = data;
      s_sof   = sof;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (s_ready) begin
            got = 1'b1;
            break;
         end
      end
      vec_count++;
      if (!got) begin
         miss_count++;
         s_valid = 1'b0;
         $display("[TB] FAIL accept_timeout: got s_ready 0 for 20 cycles, required 1 (addr %0d)", addr);
      end else begin
         exp_q.push_back('{addr: AW'(addr), data: data});
      end
      @(posedge clk);
      #1;
      s_sof = 1'b0;
   endtask

   task automatic resetDut();
      @(negedge clk);
      #1;
      s_valid     = 1'b0;
      frm_release = 1'b0;
      rst_n       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      $display("[TB] start");
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_s_ready", 32'(s_ready), 1);
      checkOutput("rst_wr_en", 32'(wr_en), 0);
      checkOutput("rst_frm_valid", 32'(frm_valid), 0);
      checkOutput("rst_frm_base", 32'(frm_base), 0);
      checkOutput("rst_err", 32'(err_sticky), 0);
      rst_n = 1'b1;

      // Two back-to-back frames with no release; the writer must then stall.
      for (int i = 0; i < 2 * FRAME; i++) begin
         applyStimulus(DW'(i), (i == 0) || (i == FRAME), i);
         if (i == FRAME - 1) checkOutput("frm_valid_before_commit", 32'(frm_valid), 0);
         if (i == FRAME) begin
            checkOutput("frm_valid_frame0", 32'(frm_valid), 1);
            checkOutput("frm_bank_frame0", 32'(frm_bank), 0);
            checkOutput("frm_base_frame0", 32'(frm_base), 0);
         end
      end
      s_data = 8'hAA;
      checkOutput("s_ready_both_full", 32'(s_ready), 0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("s_ready_still_stalled", 32'(s_ready), 0);
      checkOutput("frm_bank_stalled", 32'(frm_bank), 0);
      s_valid = 1'b0;

      // Releasing bank 0 frees it for the writer and offers bank 1.
      frm_release = 1'b1;
      @(posedge clk);
      #1;
      frm_release = 1'b0;
      checkOutput("rel_frm_bank", 32'(frm_bank), 1);
      checkOutput("rel_frm_base", 32'(frm_base), FRAME);
      checkOutput("rel_frm_valid", 32'(frm_valid), 1);
      checkOutput("rel_s_ready", 32'(s_ready), 1);
      applyStimulus(8'h55, 1'b1, 0);
      s_valid = 1'b0;

      // Release coincident with the last pixel of the bank-1 frame.
      resetDut();
      for (int i = 0; i < 2 * FRAME - 1; i++) applyStimulus(DW'(i * 3), i == 0, i);
      frm_release = 1'b1;
      applyStimulus(8'hC3, 1'b0, 2 * FRAME - 1);
      frm_release = 1'b0;
      s_valid = 1'b0;
      checkOutput("coinc_frm_bank", 32'(frm_bank), 1);
      checkOutput("coinc_frm_valid_gap", 32'(frm_valid), 0);
      checkOutput("coinc_s_ready", 32'(s_ready), 1);
      @(posedge clk);
      #1;
      checkOutput("coinc_frm_valid", 32'(frm_valid), 1);
      checkOutput("coinc_frm_base", 32'(frm_base), FRAME);
      checkOutput("coinc_s_ready_after", 32'(s_ready), 1);
      checkOutput("coinc_err", 32'(err_sticky), 0);

      // Start-of-frame at pixel 100 restarts the frame at the bank base.
      resetDut();
      for (int i = 0; i < 100; i++) applyStimulus(DW'(i + 7), i == 0, i);
      applyStimulus(8'hEE, 1'b1, 0);
      checkOutput("sof_err", 32'(err_sticky), 1);
      for (int j = 1; j < FRAME; j++) begin
         applyStimulus(DW'(j ^ 8'h5A), 1'b0, j);
         if (j == FRAME - 2) checkOutput("sof_frm_valid_early", 32'(frm_valid), 0);
      end
      s_valid = 1'b0;
      checkOutput("sof_frm_valid_at_last", 32'(frm_valid), 0);
      @(posedge clk);
      #1;
      checkOutput("sof_frm_valid", 32'(frm_valid), 1);
      checkOutput("sof_frm_base", 32'(frm_base), 0);

      // Reset in the middle of a bank-1 frame, then an illegal release.
      for (int i = 0; i < 300; i++) applyStimulus(DW'(i + 1), i == 0, FRAME + i);
      s_data = 8'h99;
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_wr_en", 32'(wr_en), 0);
      checkOutput("midrst_wr_addr", 32'(wr_addr), 0);
      checkOutput("midrst_wr_data", 32'(wr_data), 0);
      checkOutput("midrst_frm_valid", 32'(frm_valid), 0);
      checkOutput("midrst_frm_bank", 32'(frm_bank), 0);
      checkOutput("midrst_frm_base", 32'(frm_base), 0);
      checkOutput("midrst_err", 32'(err_sticky), 0);
      checkOutput("midrst_s_ready", 32'(s_ready), 1);
      s_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(8'h77, 1'b1, 0);
      s_valid = 1'b0;
      frm_release = 1'b1;
      @(posedge clk);
      #1;
      frm_release = 1'b0;
      checkOutput("badrel_err", 32'(err_sticky), 1);
      checkOutput("badrel_frm_bank", 32'(frm_bank), 0);
      checkOutput("badrel_frm_valid", 32'(frm_valid), 0);
      checkOutput("badrel_s_ready", 32'(s_ready), 1);
      applyStimulus(8'h78, 1'b0, 1);
      s_valid = 1'b0;

      repeat (3) @(negedge clk);
      checkOutput("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
      $finish;
   end

endmodule
